// File: rtl/lvds_bert_seq.sv
`default_nettype none
// ============================================================================
// lvds_bert_seq : bit-error-test sequencer for one LVDS lane (CLKF domain).
// Optional continuous-window mode: define LVDS_BERT_SEQ_CONT_EN.
// Revision: 1.0
// ============================================================================
module lvds_bert_seq #(
  parameter int CLR_CYC     = 4,
  parameter int SETTLE_CYC  = 256,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int WIN_W       = 32
) (
  input  logic             CLKF,
  input  logic             RSTXF,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic [63:0]      ERR_LIMIT,
  input  logic             PHY_INIT,
  input  logic             ALIGNED,
  input  logic [63:0]      ERR_CNT,
  input  logic [59:0]      RECV_CNT,
`ifdef LVDS_BERT_SEQ_CONT_EN
  input  logic             CONT,
`endif
  output logic             CLR,
  output logic [1:0]       PATTERN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [1:0]       FAIL_CODE,
  output logic [63:0]      RES_ERR,
  output logic [59:0]      RES_RECV
);

  localparam int CNT_W = (WIN_W > 32) ? WIN_W : 32;
  localparam logic [CNT_W-1:0] CLR_LAST     = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_MEASURE   = 3'd4,
    S_END       = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [WIN_W-1:0]  win_m1;
  logic [63:0]       err_limit;
  logic [63:0]       err_base;
  logic [59:0]       recv_base;
  logic [63:0]       err_delta;
  logic [59:0]       recv_delta;
  logic              locked;
  logic              cont;
  logic              base_load;
  logic              res_load;
  logic              win_restart;
  logic              abort_hit;
  logic              end_entry;
  logic              start_take;
  logic              pass_n;
  logic [1:0]        code_n;

`ifdef LVDS_BERT_SEQ_CONT_EN
  assign cont = CONT;
`else
  assign cont = 1'b0;
`endif

  // Modular subtraction gives the right delta even when the lane counters wrap.
  assign err_delta  = ERR_CNT - err_base;
  assign recv_delta = RECV_CNT - recv_base;
  assign locked     = ALIGNED && !PHY_INIT;
  assign abort_hit  = ABORT && (state != S_IDLE);
  assign start_take = (state == S_IDLE) && START && !ABORT;
  assign end_entry  = (state_n == S_END) && (state != S_END);
  assign pass_n     = (code_n == 2'd0) && (err_delta <= err_limit);

  always_comb begin
    state_n     = state;
    base_load   = 1'b0;
    res_load    = 1'b0;
    win_restart = 1'b0;
    code_n      = 2'd0;
    case (state)
      S_IDLE: begin
        if (start_take) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        if (cnt == CLR_LAST) state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked) begin
          state_n = S_SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n = S_END;
          code_n  = 2'd1;
        end
      end
      S_SETTLE: begin
        if (!locked) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_n   = S_MEASURE;
          base_load = 1'b1;
        end
      end
      S_MEASURE: begin
        if (!ALIGNED) begin
          state_n  = S_END;
          res_load = 1'b1;
          code_n   = 2'd2;
        end else if (cnt == CNT_W'(win_m1)) begin
          res_load = 1'b1;
          if (recv_delta == '0) begin
            state_n = S_END;
            code_n  = 2'd3;
          end else if (cont) begin
            win_restart = 1'b1;
            base_load   = 1'b1;
          end else begin
            state_n = S_END;
          end
        end
      end
      S_END: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (abort_hit) begin
      state_n     = S_IDLE;
      base_load   = 1'b0;
      res_load    = 1'b0;
      win_restart = 1'b0;
    end
  end

  always_ff @(posedge CLKF or negedge RSTXF) begin
    if (!RSTXF) begin
      state     <= S_IDLE;
      cnt       <= '0;
      win_m1    <= '0;
      err_limit <= '0;
      err_base  <= '0;
      recv_base <= '0;
      CLR       <= 1'b0;
      PATTERN   <= 2'd1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      FAIL_CODE <= 2'd0;
      RES_ERR   <= '0;
      RES_RECV  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= ((state_n != state) || win_restart || (state_n == S_IDLE)) ? '0 : cnt + CNT_W'(1);
      CLR     <= (state_n == S_CLEAR);
      PATTERN <= (state_n == S_IDLE) ? 2'd1 : 2'd0;
      BUSY    <= (state_n != S_IDLE);
      DONE    <= end_entry || win_restart || abort_hit;
      if (start_take) begin
        win_m1    <= (WINDOW == '0) ? '0 : WINDOW - WIN_W'(1);
        err_limit <= ERR_LIMIT;
        PASS      <= 1'b0;
        FAIL_CODE <= 2'd0;
        RES_ERR   <= '0;
        RES_RECV  <= '0;
      end
      if (base_load) begin
        err_base  <= ERR_CNT;
        recv_base <= RECV_CNT;
      end
      if (res_load) begin
        RES_ERR  <= err_delta;
        RES_RECV <= recv_delta;
      end
      if (end_entry || win_restart) begin
        FAIL_CODE <= code_n;
        PASS      <= pass_n;
      end
      if (abort_hit) PASS <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lvds_bert_seq.sv
`timescale 1ns/1ps
// Bench for lvds_bert_seq: phase/elapsed-time reference model plus directed and random tests.
module tb_lvds_bert_seq;
  localparam int CLR_CYC = 4, SETTLE_CYC = 16, TIMEOUT_CYC = 64, WIN_W = 16;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_WAIT = 2, P_SETTLE = 3, P_MEAS = 4, P_END = 5;

  logic             CLKF = 1'b0, RSTXF = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic [WIN_W-1:0] WINDOW = '0;
  logic [63:0]      ERR_LIMIT = '0;
  logic             PHY_INIT = 1'b1, ALIGNED = 1'b0;
  logic [63:0]      ERR_CNT = '0;
  logic [59:0]      RECV_CNT = '0;
  logic             CLR, BUSY, DONE, PASS;
  logic [1:0]       PATTERN, FAIL_CODE;
  logic [63:0]      RES_ERR;
  logic [59:0]      RES_RECV;

  lvds_bert_seq #(.CLR_CYC(CLR_CYC), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .WIN_W(WIN_W)) dut (
    .CLKF(CLKF), .RSTXF(RSTXF), .START(START), .ABORT(ABORT), .WINDOW(WINDOW),
    .ERR_LIMIT(ERR_LIMIT), .PHY_INIT(PHY_INIT), .ALIGNED(ALIGNED), .ERR_CNT(ERR_CNT),
    .RECV_CNT(RECV_CNT), .CLR(CLR), .PATTERN(PATTERN), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS), .FAIL_CODE(FAIL_CODE), .RES_ERR(RES_ERR), .RES_RECV(RES_RECV));

  always #5 CLKF = ~CLKF;

  int n_cmp = 0, n_bad = 0, step = 0;
  // reference model: current phase, entry step, latched settings and expected results
  int ph = P_IDLE, t_in = 0, lat_win = 1;
  logic [63:0] lat_lim = '0, b_err = '0, e_rerr = '0;
  logic [59:0] b_recv = '0, e_rrecv = '0;
  logic e_done = 1'b0, e_pass = 1'b0;
  logic [1:0] e_code = 2'd0;
  // lane emulator controls
  bit lane_recv = 1'b1;
  int err_rate = 0, inj = 0;
  // scenario observations
  int clr_seen, wait_k, done_k;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (step %0d)", name, act, exp, step);
    end
  endtask

  task automatic check_outputs();
    chk("CLR", CLR, (ph == P_CLEAR));
    chk("PATTERN", PATTERN, (ph == P_IDLE) ? 2'd1 : 2'd0);
    chk("BUSY", BUSY, (ph != P_IDLE));
    chk("DONE", DONE, e_done);
    chk("PASS", PASS, e_pass);
    chk("FAIL_CODE", FAIL_CODE, e_code);
    chk("RES_ERR", RES_ERR, e_rerr);
    chk("RES_RECV", RES_RECV, e_rrecv);
  endtask

  task automatic enter(input int p);
    ph = p;
    t_in = step;
  endtask

  task automatic finish_test(input logic [1:0] code);
    e_code = code;
    e_pass = (code == 2'd0) && (e_rrecv != 0) && (e_rerr <= lat_lim);
    e_done = 1'b1;
    enter(P_END);
  endtask

  // Predicts the outputs following the next edge from the inputs that edge will sample.
  task automatic model_step();
    int spent;
    logic [63:0] d_err;
    logic [59:0] d_recv;
    step++;
    spent  = step - t_in;
    e_done = 1'b0;
    d_err  = ERR_CNT - b_err;
    d_recv = RECV_CNT - b_recv;
    if (ABORT && ph != P_IDLE) begin
      enter(P_IDLE);
      e_done = 1'b1;
      e_pass = 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (START && !ABORT) begin
          lat_win = (WINDOW == 0) ? 1 : int'(WINDOW);
          lat_lim = ERR_LIMIT;
          e_pass = 1'b0; e_code = 2'd0; e_rerr = '0; e_rrecv = '0;
          enter(P_CLEAR);
        end
        P_CLEAR: if (spent == CLR_CYC) enter(P_WAIT);
        P_WAIT: begin
          if (ALIGNED && !PHY_INIT) enter(P_SETTLE);
          else if (spent == TIMEOUT_CYC) finish_test(2'd1);
        end
        P_SETTLE: begin
          if (!ALIGNED || PHY_INIT) enter(P_WAIT);
          else if (spent == SETTLE_CYC) begin
            b_err = ERR_CNT; b_recv = RECV_CNT;
            enter(P_MEAS);
          end
        end
        P_MEAS: begin
          if (!ALIGNED) begin
            e_rerr = d_err; e_rrecv = d_recv;
            finish_test(2'd2);
          end else if (spent == lat_win) begin
            e_rerr = d_err; e_rrecv = d_recv;
            finish_test((d_recv == 0) ? 2'd3 : 2'd0);
          end
        end
        default: enter(P_IDLE);
      endcase
    end
  endtask

  task automatic lane_adv();
    if (lane_recv && ALIGNED) RECV_CNT = RECV_CNT + 60'd1;
    if (inj > 0) begin
      ERR_CNT = ERR_CNT + 64'd1;
      inj--;
    end else if (err_rate > 0 && $urandom_range(0, 99) < err_rate) begin
      ERR_CNT = ERR_CNT + 64'd1;
    end
  endtask

  task automatic tick();
    lane_adv();
    model_step();
    @(posedge CLKF);
    @(negedge CLKF);
    check_outputs();
  endtask

  task automatic scenario(input int win, input logic [63:0] lim, input int inj_at, input int inj_n,
                          input int drop_at, input int abort_at, input int bound);
    int k;
    WINDOW = WIN_W'(win); ERR_LIMIT = lim; START = 1'b1;
    k = 0; clr_seen = 0; wait_k = -1; done_k = -1;
    while (k < bound && done_k < 0) begin
      if (k == 1) START = 1'b0;
      if (k == inj_at) inj = inj_n;
      if (k == drop_at) ALIGNED = 1'b0;
      ABORT = (k == abort_at);
      tick();
      if (CLR) clr_seen++;
      if (wait_k < 0 && clr_seen > 0 && !CLR && BUSY) wait_k = k;
      if (DONE) done_k = k;
      k++;
    end
    START = 1'b0; ABORT = 1'b0;
    if (done_k < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: no DONE within %0d cycles, required one", bound);
    end
  endtask

  task automatic link_up();
    ALIGNED = 1'b1; PHY_INIT = 1'b0; lane_recv = 1'b1; err_rate = 0; inj = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge CLKF);
    check_outputs();
    RSTXF = 1'b1;
    check_outputs();

    // clean link, long window
    link_up();
    scenario(1000, 64'd0, -1, 0, -1, -1, 1200);
    chk("clean_clr_cycles", clr_seen, 4);
    chk("clean_pass", PASS, 1'b1);
    chk("clean_res_err", RES_ERR, 64'd0);
    chk("clean_res_recv", RES_RECV, 60'd1000);
    chk("model_res_recv", e_rrecv, 60'd1000);
    tick(); tick();

    // five injected errors against limits 4 and 5
    link_up();
    scenario(100, 64'd4, 30, 5, -1, -1, 300);
    chk("err5_lim4_pass", PASS, 1'b0);
    chk("err5_lim4_code", FAIL_CODE, 2'd0);
    chk("err5_lim4_res_err", RES_ERR, 64'd5);
    tick(); tick();
    scenario(100, 64'd5, 30, 5, -1, -1, 300);
    chk("err5_lim5_pass", PASS, 1'b1);
    chk("model_err5_pass", e_pass, 1'b1);
    tick(); tick();

    // lock timeout
    link_up(); ALIGNED = 1'b0;
    scenario(10, 64'd0, -1, 0, -1, -1, 200);
    chk("timeout_latency", done_k - wait_k, 64);
    chk("timeout_code", FAIL_CODE, 2'd1);
    chk("timeout_pass", PASS, 1'b0);
    tick(); tick();

    // alignment lost mid-measure
    link_up();
    scenario(100, 64'd10, -1, 0, 40, -1, 300);
    chk("drop_done_cycle", done_k, 40);
    chk("drop_code", FAIL_CODE, 2'd2);
    chk("drop_pass", PASS, 1'b0);
    tick(); tick();

    // error counter wraps inside the window
    link_up(); ERR_CNT = 64'hFFFF_FFFF_FFFF_FFFE;
    scenario(50, 64'd10, 30, 3, -1, -1, 200);
    chk("wrap_res_err", RES_ERR, 64'd3);
    chk("model_wrap_res_err", e_rerr, 64'd3);
    tick(); tick();

    // abort while settling
    link_up();
    scenario(50, 64'd10, -1, 0, -1, 10, 200);
    chk("abort_done_cycle", done_k, 10);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_pass", PASS, 1'b0);
    tick(); tick();

    // no words received
    link_up(); lane_recv = 1'b0;
    scenario(20, 64'd10, -1, 0, -1, -1, 200);
    chk("norecv_code", FAIL_CODE, 2'd3);
    chk("norecv_pass", PASS, 1'b0);
    tick(); tick();

    // randomized tests
    for (int t = 0; t < 40; t++) begin
      link_up();
      WINDOW    = ($urandom_range(0, 9) == 0) ? '0 : WIN_W'($urandom_range(1, 40));
      ERR_LIMIT = 64'($urandom_range(0, 3));
      err_rate  = $urandom_range(0, 15);
      lane_recv = ($urandom_range(0, 9) != 0);
      ERR_CNT   = {$urandom, $urandom};
      RECV_CNT  = 60'({$urandom, $urandom});
      START = 1'b1;
      k = 0;
      do begin
        if (k == 1) START = 1'b0;
        if (k > 1) START = ($urandom_range(0, 49) == 0);
        if (ALIGNED) ALIGNED = ($urandom_range(0, 149) != 0);
        else ALIGNED = ($urandom_range(0, 5) == 0);
        PHY_INIT = ($urandom_range(0, 79) == 0);
        ABORT = ($urandom_range(0, 399) == 0);
        tick();
        k++;
      end while (ph != P_IDLE && k < 3000);
      START = 1'b0; ABORT = 1'b0;
      tick(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
